// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : score_keeper
// Description : Converts goal-line levels into saturating per-player scores
//               and sequences each rally through serve / play / scored /
//               game-over. Scoring freezes once the winner code reports a
//               decided game; new_game or reset restarts the match.
// Revision    : 1.0 - initial release
// ============================================================================
module score_keeper #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int MAX_SCORE   = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       goal_p1,
  input  logic       goal_p2,
  input  logic       serve_btn,
  input  logic       new_game,
  input  logic [1:0] winner,
  output logic [3:0] p1s,
  output logic [3:0] p2s,
  output logic       serve_side,
  output logic       ball_en,
  output logic       point_flag,
  output logic       game_over
);

  typedef enum logic [1:0] {
    S_SERVE     = 2'd0,
    S_PLAY      = 2'd1,
    S_SCORED    = 2'd2,
    S_GAME_OVER = 2'd3
  } state_t;

  // Counter is sized for the largest legal hold (2^26-1 cycles).
  localparam logic [25:0] c_hold_last = 26'(HOLD_CYCLES - 1);
  localparam logic [3:0]  c_max_score = 4'(MAX_SCORE);

  state_t      r_state;
  logic [25:0] r_hold;
  logic        r_goal1_q;
  logic        r_goal2_q;

  state_t      w_state_nxt;
  logic [25:0] w_hold_nxt;
  logic [3:0]  w_p1s_nxt;
  logic [3:0]  w_p2s_nxt;
  logic        w_serve_nxt;
  logic        w_point_nxt;
  logic        w_g1_rise;
  logic        w_g2_rise;
  logic        w_win_decided;

  // Goals are levels; only the first cycle of a level counts as a goal.
  assign w_g1_rise     = goal_p1 & ~r_goal1_q;
  assign w_g2_rise     = goal_p2 & ~r_goal2_q;
  assign w_win_decided = (winner == 2'b10) || (winner == 2'b11);

  // Next-state and next-output decode; new_game overrides all rally activity.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_p1s_nxt   = p1s;
    w_p2s_nxt   = p2s;
    w_serve_nxt = serve_side;
    w_point_nxt = 1'b0;

    if (new_game) begin
      w_state_nxt = S_SERVE;
      w_hold_nxt  = '0;
      w_p1s_nxt   = '0;
      w_p2s_nxt   = '0;
      w_serve_nxt = 1'b0;
    end else begin
      case (r_state)
        S_SERVE: begin
          if (serve_btn) w_state_nxt = S_PLAY;
        end
        S_PLAY: begin
          // A simultaneous rise on both goals is ambiguous and credits nobody.
          if (w_g1_rise ^ w_g2_rise) begin
            if (w_g1_rise) begin
              if (p1s < c_max_score) w_p1s_nxt = p1s + 4'd1;
              w_serve_nxt = 1'b1;
            end else begin
              if (p2s < c_max_score) w_p2s_nxt = p2s + 4'd1;
              w_serve_nxt = 1'b0;
            end
            w_point_nxt = 1'b1;
            w_state_nxt = S_SCORED;
            w_hold_nxt  = '0;
          end
        end
        S_SCORED: begin
          // The winner code is read only at the end of the hold, by which
          // time it reflects the freshly credited point.
          if (r_hold == c_hold_last) begin
            w_state_nxt = w_win_decided ? S_GAME_OVER : S_SERVE;
            w_hold_nxt  = '0;
          end else begin
            w_hold_nxt = r_hold + 26'd1;
          end
        end
        S_GAME_OVER: begin
          w_state_nxt = S_GAME_OVER;
        end
        default: begin
          w_state_nxt = S_SERVE;
        end
      endcase
    end
  end

  // State, counters and registered outputs; goal history follows the inputs
  // every cycle and is forced high in reset so held goals are not counted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_SERVE;
      r_hold     <= '0;
      r_goal1_q  <= 1'b1;
      r_goal2_q  <= 1'b1;
      p1s        <= '0;
      p2s        <= '0;
      serve_side <= 1'b0;
      ball_en    <= 1'b0;
      point_flag <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold     <= w_hold_nxt;
      r_goal1_q  <= goal_p1;
      r_goal2_q  <= goal_p2;
      p1s        <= w_p1s_nxt;
      p2s        <= w_p2s_nxt;
      serve_side <= w_serve_nxt;
      ball_en    <= (w_state_nxt == S_PLAY);
      point_flag <= w_point_nxt;
      game_over  <= (w_state_nxt == S_GAME_OVER);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_keeper
// Description : Self-checking bench for score_keeper: directed scenarios plus
//               a randomized run against a rally-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_keeper;

  localparam int HOLD = 4;
  localparam int MAXS = 9;
  localparam int PH_SERVE = 0, PH_PLAY = 1, PH_SCORED = 2, PH_OVER = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       goal_p1 = 1'b0, goal_p2 = 1'b0, serve_btn = 1'b0, new_game = 1'b0;
  logic [1:0] winner = 2'b01;
  logic [3:0] p1s, p2s;
  logic       serve_side, ball_en, point_flag, game_over;

  int total = 0;
  int bad = 0;

  // reference model of the rally
  int   m_p1 = 0, m_p2 = 0, m_serve = 0, m_phase = PH_SERVE, m_left = 0, m_point = 0;
  logic m_prev1 = 1'b1, m_prev2 = 1'b1;
  logic win_stub = 1'b0;
  logic [1:0] w_pend = 2'b01;

  score_keeper #(.HOLD_CYCLES(HOLD), .MAX_SCORE(MAXS)) dut (
    .clk(clk), .reset(reset), .goal_p1(goal_p1), .goal_p2(goal_p2),
    .serve_btn(serve_btn), .new_game(new_game), .winner(winner),
    .p1s(p1s), .p2s(p2s), .serve_side(serve_side), .ball_en(ball_en),
    .point_flag(point_flag), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Advance the rally model by one clock using the inputs seen at the edge.
  task automatic model_step();
    logic r1, r2;
    r1 = goal_p1 && !m_prev1;
    r2 = goal_p2 && !m_prev2;
    m_prev1 = goal_p1;
    m_prev2 = goal_p2;
    m_point = 0;
    if (!reset) begin
      m_p1 = 0; m_p2 = 0; m_serve = 0; m_phase = PH_SERVE; m_left = 0;
      m_prev1 = 1'b1; m_prev2 = 1'b1;
    end else if (new_game) begin
      m_p1 = 0; m_p2 = 0; m_serve = 0; m_phase = PH_SERVE; m_left = 0;
    end else if (m_phase == PH_SERVE) begin
      if (serve_btn) m_phase = PH_PLAY;
    end else if (m_phase == PH_PLAY) begin
      if (r1 != r2) begin
        if (r1) begin m_p1 = (m_p1 + 1 > MAXS) ? MAXS : m_p1 + 1; m_serve = 1; end
        else    begin m_p2 = (m_p2 + 1 > MAXS) ? MAXS : m_p2 + 1; m_serve = 0; end
        m_point = 1;
        m_phase = PH_SCORED;
        m_left  = HOLD;
      end
    end else if (m_phase == PH_SCORED) begin
      m_left = m_left - 1;
      if (m_left == 0) m_phase = (winner == 2'b10 || winner == 2'b11) ? PH_OVER : PH_SERVE;
    end
  endtask

  // One clock: step the model, then update the winner stub one cycle late.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    winner = w_pend;
    if (!win_stub)    w_pend = 2'b01;
    else if (m_p1 >= 5) w_pend = 2'b10;
    else if (m_p2 >= 5) w_pend = 2'b11;
    else              w_pend = 2'b01;
  endtask

  task automatic do_reset();
    reset = 1'b0; tick(); tick(); reset = 1'b1; tick();
  endtask

  task automatic test_reset();
    goal_p1 = 0; goal_p2 = 0; serve_btn = 0; new_game = 0;
    reset = 1'b0; tick(); tick();
    total++; if (p1s !== 4'd0)      begin bad++; $display("FAIL rst_p1s got=%0d exp=0", p1s); end
    total++; if (p2s !== 4'd0)      begin bad++; $display("FAIL rst_p2s got=%0d exp=0", p2s); end
    total++; if (serve_side !== 0)  begin bad++; $display("FAIL rst_serve got=%b exp=0", serve_side); end
    total++; if (ball_en !== 0)     begin bad++; $display("FAIL rst_ball_en got=%b exp=0", ball_en); end
    total++; if (point_flag !== 0)  begin bad++; $display("FAIL rst_point got=%b exp=0", point_flag); end
    total++; if (game_over !== 0)   begin bad++; $display("FAIL rst_game_over got=%b exp=0", game_over); end
    reset = 1'b1; tick();
  endtask

  task automatic test_single_point();
    serve_btn = 1; tick(); serve_btn = 0;
    total++; if (ball_en !== 1) begin bad++; $display("FAIL sp_ball_en got=%b exp=1", ball_en); end
    goal_p1 = 1; tick();
    total++; if (p1s !== 4'd1)     begin bad++; $display("FAIL sp_p1s got=%0d exp=1", p1s); end
    total++; if (point_flag !== 1) begin bad++; $display("FAIL sp_point got=%b exp=1", point_flag); end
    total++; if (serve_side !== 1) begin bad++; $display("FAIL sp_serve got=%b exp=1", serve_side); end
    total++; if (ball_en !== 0)    begin bad++; $display("FAIL sp_ball_off got=%b exp=0", ball_en); end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) serve_btn = 1;   // still in the hold: must be ignored
      tick();
      total++; if (p1s !== 4'd1 || point_flag !== 0 || ball_en !== 0) begin
        bad++; $display("FAIL sp_hold%0d got p1s=%0d pf=%b be=%b exp 1/0/0", i, p1s, point_flag, ball_en);
      end
    end
    tick();  // last hold cycle, serve_btn still high
    total++; if (ball_en !== 0) begin bad++; $display("FAIL sp_hold_end got=%b exp=0", ball_en); end
    goal_p1 = 0; tick(); serve_btn = 0;
    total++; if (ball_en !== 1) begin bad++; $display("FAIL sp_reserve got=%b exp=1", ball_en); end
  endtask

  task automatic test_simultaneous();
    goal_p1 = 1; goal_p2 = 1; tick();
    total++; if (p1s !== 4'd1 || p2s !== 4'd0) begin bad++; $display("FAIL sim_scores got=%0d/%0d exp=1/0", p1s, p2s); end
    total++; if (point_flag !== 0) begin bad++; $display("FAIL sim_point got=%b exp=0", point_flag); end
    total++; if (ball_en !== 1)    begin bad++; $display("FAIL sim_ball_en got=%b exp=1", ball_en); end
    goal_p1 = 0; goal_p2 = 0; tick();
    goal_p2 = 1; tick(); goal_p2 = 0;
    total++; if (p2s !== 4'd1 || serve_side !== 0 || point_flag !== 1) begin
      bad++; $display("FAIL sim_p2pt got p2s=%0d ss=%b pf=%b exp 1/0/1", p2s, serve_side, point_flag);
    end
    repeat (4) tick();
  endtask

  task automatic test_goal_through_reset();
    reset = 0; goal_p2 = 1; tick(); tick();
    reset = 1; tick();
    serve_btn = 1; tick(); serve_btn = 0;
    repeat (3) tick();
    total++; if (p2s !== 4'd0 || point_flag !== 0) begin bad++; $display("FAIL gtr_p2s got=%0d pf=%b exp 0/0", p2s, point_flag); end
    total++; if (ball_en !== 1) begin bad++; $display("FAIL gtr_ball_en got=%b exp=1", ball_en); end
    goal_p2 = 0; tick();
  endtask

  task automatic test_game_over();
    win_stub = 1; do_reset();
    for (int i = 0; i < 5; i++) begin
      serve_btn = 1; tick(); serve_btn = 0;
      goal_p1 = 1; tick(); goal_p1 = 0;
      repeat (HOLD) tick();
    end
    total++; if (game_over !== 1 || p1s !== 4'd5 || ball_en !== 0) begin
      bad++; $display("FAIL go_enter got go=%b p1s=%0d be=%b exp 1/5/0", game_over, p1s, ball_en);
    end
    goal_p1 = 1; tick(); goal_p1 = 0; serve_btn = 1; tick(); serve_btn = 0; goal_p1 = 1; tick(); goal_p1 = 0; tick();
    total++; if (p1s !== 4'd5 || game_over !== 1 || ball_en !== 0) begin
      bad++; $display("FAIL go_frozen got p1s=%0d go=%b be=%b exp 5/1/0", p1s, game_over, ball_en);
    end
    new_game = 1; goal_p1 = 1; tick(); new_game = 0; goal_p1 = 0;
    total++; if (p1s !== 4'd0 || game_over !== 0 || serve_side !== 0 || point_flag !== 0) begin
      bad++; $display("FAIL go_new got p1s=%0d go=%b ss=%b pf=%b exp 0/0/0/0", p1s, game_over, serve_side, point_flag);
    end
    serve_btn = 1; tick(); serve_btn = 0;
    total++; if (ball_en !== 1) begin bad++; $display("FAIL go_serve got=%b exp=1", ball_en); end
    win_stub = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 11; i++) begin
      serve_btn = 1; tick(); serve_btn = 0;
      goal_p2 = 1; tick(); goal_p2 = 0;
      total++; if (p2s !== 4'((i + 1 > MAXS) ? MAXS : i + 1) || point_flag !== 1) begin
        bad++; $display("FAIL sat_pt%0d got p2s=%0d pf=%b exp %0d/1", i, p2s, point_flag, (i + 1 > MAXS) ? MAXS : i + 1);
      end
      repeat (HOLD) tick();
    end
    total++; if (game_over !== 0) begin bad++; $display("FAIL sat_go got=%b exp=0", game_over); end
  endtask

  task automatic test_reset_mid_hold();
    serve_btn = 1; tick(); serve_btn = 0;
    goal_p1 = 1; tick(); goal_p1 = 0;
    reset = 0; tick();
    total++; if (p1s !== 0 || p2s !== 0 || serve_side !== 0 || ball_en !== 0 || point_flag !== 0 || game_over !== 0) begin
      bad++; $display("FAIL rmh_vals got %0d %0d %b %b %b %b exp all 0", p1s, p2s, serve_side, ball_en, point_flag, game_over);
    end
    reset = 1; repeat (5) tick();
    total++; if (ball_en !== 0) begin bad++; $display("FAIL rmh_idle got=%b exp=0", ball_en); end
    serve_btn = 1; tick(); serve_btn = 0;
    total++; if (ball_en !== 1) begin bad++; $display("FAIL rmh_serve got=%b exp=1", ball_en); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      win_stub  = (c >= 2000);
      if ($urandom_range(3) == 0) goal_p1 = ~goal_p1;
      if ($urandom_range(3) == 0) goal_p2 = ~goal_p2;
      serve_btn = ($urandom_range(2) == 0);
      new_game  = ($urandom_range(249) == 0);
      reset     = ($urandom_range(399) != 0);
      tick();
      total++; if (p1s !== 4'(m_p1) || p2s !== 4'(m_p2)) begin
        bad++; $display("FAIL rnd_scores c=%0d got %0d/%0d exp %0d/%0d", c, p1s, p2s, m_p1, m_p2);
      end
      total++; if (serve_side !== 1'(m_serve) || point_flag !== 1'(m_point)) begin
        bad++; $display("FAIL rnd_flags c=%0d got ss=%b pf=%b exp %0d/%0d", c, serve_side, point_flag, m_serve, m_point);
      end
      total++; if (ball_en !== (m_phase == PH_PLAY) || game_over !== (m_phase == PH_OVER)) begin
        bad++; $display("FAIL rnd_state c=%0d got be=%b go=%b exp phase=%0d", c, ball_en, game_over, m_phase);
      end
    end
    reset = 1; new_game = 0; serve_btn = 0;
  endtask

  initial begin
    test_reset();
    test_single_point();
    test_simultaneous();
    test_goal_through_reset();
    test_game_over();
    test_saturation();
    test_reset_mid_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Upstream stage of the winner-detection block. Turns raw goal events from the ball/collision logic into per-player 4-bit scores (p1s, p2s).
- Sequences each rally through a serve / play / point-scored / game-over FSM.
- Freezes scoring once the downstream winner code reports a decided game.
- Outputs drive the winner block and the score display directly.

Parameters:
- HOLD_CYCLES, 50000000, clocks the FSM stays in SCORED after a point (1 s at 50 MHz); legal range 2 to 2^26-1.
- MAX_SCORE, 9, saturation value for each score; must be at most 15.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low; clock clk.
- goal_p1  input  1  level; high while the ball is in player 2's goal, so player 1 scores.
- goal_p2  input  1  level; high while the ball is in player 1's goal, so player 2 scores.
- serve_btn  input  1  single-cycle pulse, already debounced; launches the ball.
- new_game  input  1  single-cycle pulse; clears scores without a full reset.
- winner  input  2  code from the winner block: 00 reset, 01 in play, 10 P1 won, 11 P2 won.
- p1s  output  4  player 1 score.
- p2s  output  4  player 2 score.
- serve_side  output  1  next server: 0 = P1, 1 = P2.
- ball_en  output  1  high only in PLAY; gates ball motion.
- point_flag  output  1  one-cycle pulse on the cycle a point is credited.
- game_over  output  1  high in GAME_OVER.

Behaviour:
- Reset (reset==0 at a clk edge):
  - p1s=0, p2s=0, serve_side=0, ball_en=0, point_flag=0, game_over=0.
  - state=SERVE, hold counter=0.
  - Goal edge registers set to 1, so a goal held high through reset release is never counted.
  - Reset mid-rally or mid-hold aborts immediately with the same values.
- Edge detect: g1_rise = goal_p1 & ~goal_p1_q; likewise for goal_p2. The _q registers update every cycle in every state.
- States are SERVE, PLAY, SCORED, GAME_OVER.
- SERVE:
  - ball_en=0; goals ignored.
  - serve_btn==1 moves to PLAY next cycle; ball_en=1 from that cycle on.
- PLAY: ball_en=1.
  - Exactly one of g1_rise/g2_rise: increment that score, saturating at MAX_SCORE.
    - serve_side <= 1 if P1 scored, 0 if P2 scored (the conceding player serves).
    - point_flag=1 for that single cycle.
    - Next state SCORED, hold counter cleared.
  - g1_rise and g2_rise in the same cycle: no score change, no point_flag, stay in PLAY.
- SCORED:
  - ball_en=0; counter increments each cycle.
  - On the cycle counter == HOLD_CYCLES-1:
    - winner==10 or winner==11 moves to GAME_OVER.
    - Otherwise moves to SERVE.
  - The winner block registers the new scores one cycle after the update; HOLD_CYCLES >= 2 guarantees the updated winner code is sampled.
- GAME_OVER:
  - game_over=1, ball_en=0.
  - Scores frozen; goals and serve_btn ignored.
  - Left only by new_game or reset.
- new_game (any state, reset inactive):
  - Next cycle: p1s=p2s=0, serve_side=0, state=SERVE, counter=0, point_flag=0.
  - Takes priority over a same-cycle goal or serve_btn.
- All outputs are registered; scores change exactly 1 cycle after the sampled rising edge.
- Scores never exceed MAX_SCORE and never wrap.

Test Plan (HOLD_CYCLES=4):
- Reset, serve_btn pulse, goal_p1 high for 5 cycles -> ball_en=1 one cycle after serve; p1s=1 once (not 5); point_flag high 1 cycle; serve_side=1; ball_en=0 for 4 cycles, then state SERVE.
- goal_p1 and goal_p2 rise in the same PLAY cycle -> p1s/p2s unchanged, point_flag=0, ball_en stays 1.
- goal_p2 held high across the reset deassertion edge -> p2s stays 0.
- Drive 5 P1 points with winner stub returning 10 one cycle after p1s==5 -> game_over=1 after hold; further goals and serve_btn leave p1s=5; new_game gives p1s=0, game_over=0, state SERVE.
- Force p2s to MAX_SCORE=9 with winner held 01, then another P2 goal -> p2s stays 9, point_flag still pulses.
- Reset asserted on the 2nd SCORED cycle -> next cycle all outputs at reset values; no transition to SERVE from the stale hold.
